// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
// Round-robin arbiter that shares the single register_file write port
// (we/wa/wd) among NREQ write requesters using a req/gnt handshake.
// The grant is combinational; the write itself is registered, so a grant
// in cycle N is presented on rf_* from edge N+1 and lands in the
// register file on edge N+2.
//
// Build option:
//   RF_INIT_CLEAR_EN - when defined, reset enters an INIT state that sweeps
//                      zero into every register (2^AW cycles, busy=1, no
//                      grants) before arbitration starts. When undefined,
//                      reset enters arbitration directly and busy is tied 0.

module rf_write_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      gnt,
    output logic                 rf_we,
    output logic [AW-1:0]        rf_wa,
    output logic [DW-1:0]        rf_wd,
    output logic                 busy
);

    // Width of a requester index / round-robin pointer.
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    // Requester count and the constant one at pointer-plus-carry width,
    // used for the modulo-NREQ wrap.
    localparam logic [PW:0] NREQ_L = (PW + 1)'(NREQ);
    localparam logic [PW:0] ONE_L  = {{PW{1'b0}}, 1'b1};

    // Round-robin pointer: the requester with highest priority next cycle.
    logic [PW-1:0] ptr_r;
    logic [PW-1:0] ptr_nxt_s;

    // Registered write port and its next values.
    logic          rf_we_r;
    logic [AW-1:0] rf_wa_r;
    logic [DW-1:0] rf_wd_r;
    logic          rf_we_nxt_s;
    logic [AW-1:0] rf_wa_nxt_s;
    logic [DW-1:0] rf_wd_nxt_s;

    // Arbitration results.
    logic          run_s;
    logic          win_vld_s;
    logic [PW-1:0] win_idx_s;
    logic [NREQ-1:0] gnt_s;
    logic [AW-1:0] win_addr_s;
    logic [DW-1:0] win_data_s;

    // Proposed write-port update when the arbiter is in its serving state.
    logic          run_we_s;
    logic [AW-1:0] run_wa_s;
    logic [DW-1:0] run_wd_s;
    logic [PW-1:0] run_ptr_s;
    logic [PW:0]   inc_s;

`ifdef RF_INIT_CLEAR_EN
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [AW-1:0] CNT_ONE = {{(AW-1){1'b0}}, 1'b1};

    state_t        state_r;
    state_t        state_nxt_s;
    logic [AW-1:0] cnt_r;
    logic [AW-1:0] cnt_nxt_s;

    assign run_s = (state_r == ST_RUN);
    assign busy  = (state_r == ST_INIT);
`else
    assign run_s = 1'b1;
    assign busy  = 1'b0;
`endif

    // Scan requesters from ptr upward, wrapping modulo NREQ; first active wins.
    always_comb begin
        logic [PW:0]   sum_v;
        logic [PW-1:0] idx_v;
        logic [PW-1:0] k_v;
        win_vld_s = 1'b0;
        win_idx_s = '0;
        sum_v     = '0;
        idx_v     = '0;
        k_v       = '0;
        for (int k = 0; k < NREQ; k++) begin
            k_v   = k[PW-1:0];
            sum_v = {1'b0, ptr_r} + {1'b0, k_v};
            // The true index is below NREQ, so PW-bit arithmetic is exact.
            if (sum_v >= NREQ_L) begin
                idx_v = ptr_r + k_v - NREQ_L[PW-1:0];
            end else begin
                idx_v = ptr_r + k_v;
            end
            if (run_s && !win_vld_s && req[idx_v]) begin
                win_vld_s = 1'b1;
                win_idx_s = idx_v;
            end else begin
                win_vld_s = win_vld_s;
            end
        end
    end

    // Decode the winner into a one-hot grant and select its address/data.
    always_comb begin
        gnt_s      = '0;
        win_addr_s = '0;
        win_data_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_vld_s && (win_idx_s == i[PW-1:0])) begin
                gnt_s[i]   = 1'b1;
                win_addr_s = req_addr[i*AW +: AW];
                win_data_s = req_data[i*DW +: DW];
            end else begin
                gnt_s[i]   = 1'b0;
            end
        end
    end

    assign gnt = gnt_s;

    // Serving-state update: forward the granted write and advance ptr past the winner.
    always_comb begin
        run_we_s  = 1'b0;
        run_wa_s  = rf_wa_r;
        run_wd_s  = rf_wd_r;
        run_ptr_s = ptr_r;
        inc_s     = {1'b0, win_idx_s} + ONE_L;
        if (win_vld_s) begin
            run_we_s = 1'b1;
            run_wa_s = win_addr_s;
            run_wd_s = win_data_s;
            if (inc_s >= NREQ_L) begin
                run_ptr_s = '0;
            end else begin
                run_ptr_s = inc_s[PW-1:0];
            end
        end else begin
            // No transfer: drop we, hold address/data, keep ptr.
            run_we_s = 1'b0;
        end
    end

`ifdef RF_INIT_CLEAR_EN
    // Next-state logic: clear sweep in INIT, arbitration in RUN.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        rf_we_nxt_s = run_we_s;
        rf_wa_nxt_s = run_wa_s;
        rf_wd_nxt_s = run_wd_s;
        ptr_nxt_s   = run_ptr_s;
        case (state_r)
            ST_INIT: begin
                rf_we_nxt_s = 1'b1;
                rf_wa_nxt_s = cnt_r;
                rf_wd_nxt_s = '0;
                ptr_nxt_s   = ptr_r;
                cnt_nxt_s   = cnt_r + CNT_ONE;
                if (&cnt_r) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_INIT;
                end
            end
            ST_RUN: begin
                state_nxt_s = ST_RUN;
            end
            default: begin
                // Unreachable encoding: restart the sweep cleanly.
                state_nxt_s = ST_INIT;
                cnt_nxt_s   = '0;
                rf_we_nxt_s = 1'b0;
                rf_wa_nxt_s = '0;
                rf_wd_nxt_s = '0;
                ptr_nxt_s   = '0;
            end
        endcase
    end

    // Sweep state and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_INIT;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end
`else
    // Next-state logic: always arbitrating.
    always_comb begin
        rf_we_nxt_s = run_we_s;
        rf_wa_nxt_s = run_wa_s;
        rf_wd_nxt_s = run_wd_s;
        ptr_nxt_s   = run_ptr_s;
    end
`endif

    // Write-port pipeline register and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we_r <= 1'b0;
            rf_wa_r <= '0;
            rf_wd_r <= '0;
            ptr_r   <= '0;
        end else begin
            rf_we_r <= rf_we_nxt_s;
            rf_wa_r <= rf_wa_nxt_s;
            rf_wd_r <= rf_wd_nxt_s;
            ptr_r   <= ptr_nxt_s;
        end
    end

    assign rf_we = rf_we_r;
    assign rf_wa = rf_wa_r;
    assign rf_wd = rf_wd_r;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Testbench for rf_write_arbiter: directed scenarios plus a randomized run,
// all checked against a behavioural model (rotating-priority pick, a
// one-deep write pipeline and a 32-entry register-file image). Sweep
// scenarios are built only when RF_INIT_CLEAR_EN is defined.

module tb_rf_write_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 5;
    localparam int DW   = 32;
`ifdef RF_INIT_CLEAR_EN
    localparam int SWEEP = 32;
`else
    localparam int SWEEP = 0;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req = '0;
    logic [NREQ*AW-1:0]  req_addr = '0;
    logic [NREQ*DW-1:0]  req_data = '0;
    logic [NREQ-1:0]     gnt;
    logic                rf_we;
    logic [AW-1:0]       rf_wa;
    logic [DW-1:0]       rf_wd;
    logic                busy;

    rf_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_addr (req_addr),
        .req_data (req_data),
        .gnt      (gnt),
        .rf_we    (rf_we),
        .rf_wa    (rf_wa),
        .rf_wd    (rf_wd),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Stand-in register file fed by the arbiter's write port.
    logic          preload = 1'b0;
    logic [DW-1:0] rf_mem [0:31];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= 32'hDEAD_0000 | i;
        end else if (rf_we) begin
            rf_mem[rf_wa] <= rf_wd;
        end
    end

    // Reference model state.
    int            m_ptr;
    int            m_cnt;
    int            m_init_left;
    logic          exp_we;
    logic [AW-1:0] exp_wa;
    logic [DW-1:0] exp_wd;
    logic [DW-1:0] m_mem [0:31];
    logic [NREQ-1:0] exp_gnt, obs_gnt;
    logic          exp_busy, obs_busy;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    // Rotating priority: first requester at or after m_ptr (mod NREQ).
    function automatic int pick(input logic [NREQ-1:0] r);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    // Drive one cycle, sample grant/busy mid-cycle, advance the model at the edge.
    task automatic step(input logic [NREQ-1:0] r, input logic [NREQ*AW-1:0] a,
                        input logic [NREQ*DW-1:0] d);
        int w;
        @(negedge clk);
        req = r; req_addr = a; req_data = d;
        #1;
        obs_gnt  = gnt;
        obs_busy = busy;
        exp_busy = (m_init_left > 0);
        w = (m_init_left > 0) ? -1 : pick(r);
        exp_gnt = (w < 0) ? 4'b0000 : (4'b0001 << w);
        @(posedge clk);
        if (exp_we) m_mem[exp_wa] = exp_wd;
        if (m_init_left > 0) begin
            exp_we = 1'b1; exp_wa = m_cnt[AW-1:0]; exp_wd = 32'd0;
            m_cnt++; m_init_left--;
        end else if (w >= 0) begin
            exp_we = 1'b1; exp_wa = a[w*AW +: AW]; exp_wd = d[w*DW +: DW];
            m_ptr = (w + 1) % NREQ;
        end else begin
            exp_we = 1'b0;
        end
        #1;
    endtask

    // Hold reset for two edges, reset the model, release just after an edge.
    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        m_ptr = 0; m_cnt = 0; m_init_left = SWEEP;
        exp_we = 1'b0; exp_wa = '0; exp_wd = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic reach_run();
        int n;
        do_reset();
        n = m_init_left;
        repeat (n) step('0, '0, '0);
    endtask

    task automatic test_reset();
        preload = 1'b1;
        do_reset();
        preload = 1'b0;
        if ({rf_we, rf_wa, rf_wd} !== {1'b0, 5'd0, 32'd0}) begin
            n_fail++; $display("FAIL reset_rf: got we=%b wa=%0d wd=%h, expected all 0", rf_we, rf_wa, rf_wd);
        end else n_pass++;
        n_total++;
        if (busy !== (SWEEP > 0)) begin
            n_fail++; $display("FAIL reset_busy: got %b expected %b", busy, (SWEEP > 0));
        end else n_pass++;
        n_total++;
        if (gnt !== 4'b0000) begin
            n_fail++; $display("FAIL reset_gnt: got %b expected 0000", gnt);
        end else n_pass++;
        n_total++;
    endtask

`ifdef RF_INIT_CLEAR_EN
    task automatic test_sweep();
        logic [AW-1:0] cw;
        do_reset();
        for (int c = 0; c < 32; c++) begin
            step('0, '0, '0);
            cw = c[AW-1:0];
            if (obs_busy !== 1'b1 || obs_gnt !== 4'b0000) begin
                n_fail++; $display("FAIL sweep_busy c=%0d: got busy=%b gnt=%b expected busy=1 gnt=0000", c, obs_busy, obs_gnt);
            end else n_pass++;
            n_total++;
            if ({rf_we, rf_wa, rf_wd} !== {1'b1, cw, 32'd0}) begin
                n_fail++; $display("FAIL sweep_write c=%0d: got we=%b wa=%0d wd=%h expected we=1 wa=%0d wd=0", c, rf_we, rf_wa, rf_wd, cw);
            end else n_pass++;
            n_total++;
        end
        step('0, '0, '0);
        if (obs_busy !== 1'b0 || {rf_we, rf_wa} !== {1'b0, 5'd31}) begin
            n_fail++; $display("FAIL sweep_end: got busy=%b we=%b wa=%0d expected busy=0 we=0 wa=31", obs_busy, rf_we, rf_wa);
        end else n_pass++;
        n_total++;
        for (int a = 0; a < 32; a++) begin
            if (rf_mem[a] !== 32'd0) begin
                n_fail++; $display("FAIL sweep_clear addr=%0d: got %h expected 0", a, rf_mem[a]);
            end else n_pass++;
            n_total++;
        end
    endtask

    task automatic test_init_holdoff();
        logic [NREQ*AW-1:0] a;
        logic [NREQ*DW-1:0] d;
        a = '0; d = '0;
        a[1*AW +: AW] = 5'd5;
        d[1*DW +: DW] = 32'h55;
        do_reset();
        for (int c = 0; c <= 32; c++) begin
            step(4'b0010, a, d);
            if (c < 32) begin
                if (obs_gnt !== 4'b0000 || obs_busy !== 1'b1) begin
                    n_fail++; $display("FAIL holdoff c=%0d: got gnt=%b busy=%b expected 0000/1", c, obs_gnt, obs_busy);
                end else n_pass++;
            end else begin
                if (obs_gnt !== 4'b0010 || obs_busy !== 1'b0) begin
                    n_fail++; $display("FAIL holdoff_first_run: got gnt=%b busy=%b expected 0010/0", obs_gnt, obs_busy);
                end else n_pass++;
            end
            n_total++;
        end
    endtask
`endif

    task automatic test_single();
        logic [NREQ*AW-1:0] a;
        logic [NREQ*DW-1:0] d;
        a = '0; d = '0;
        a[2*AW +: AW] = 5'd20;
        d[2*DW +: DW] = 32'd378;
        reach_run();
        step(4'b0100, a, d);
        if (obs_gnt !== 4'b0100) begin
            n_fail++; $display("FAIL single_gnt: got %b expected 0100", obs_gnt);
        end else n_pass++;
        n_total++;
        if ({rf_we, rf_wa, rf_wd} !== {1'b1, 5'd20, 32'd378}) begin
            n_fail++; $display("FAIL single_write: got we=%b wa=%0d wd=%0d expected 1/20/378", rf_we, rf_wa, rf_wd);
        end else n_pass++;
        n_total++;
        step('0, '0, '0);
        if (rf_mem[20] !== 32'd378 || rf_we !== 1'b0) begin
            n_fail++; $display("FAIL single_read: got rd=%0d we=%b expected 378/0", rf_mem[20], rf_we);
        end else n_pass++;
        n_total++;
    endtask

    task automatic test_round_robin();
        logic [NREQ*AW-1:0] a;
        logic [NREQ*DW-1:0] d;
        logic [NREQ-1:0]    oh;
        int g, ad;
        reach_run();
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                g  = k / 4 + ((i < k % 4) ? 1 : 0);
                ad = 8 + i + 4 * g;
                a[i*AW +: AW] = ad[AW-1:0];
                d[i*DW +: DW] = 32'h0000_A000 + ad;
            end
            step(4'b1111, a, d);
            oh = 4'b0001 << (k % 4);
            if (obs_gnt !== oh || obs_gnt !== exp_gnt) begin
                n_fail++; $display("FAIL rr_gnt k=%0d: got %b expected %b", k, obs_gnt, oh);
            end else n_pass++;
            n_total++;
            if ({rf_we, rf_wa, rf_wd} !== {exp_we, exp_wa, exp_wd}) begin
                n_fail++; $display("FAIL rr_write k=%0d: got %b/%0d/%h expected %b/%0d/%h", k, rf_we, rf_wa, rf_wd, exp_we, exp_wa, exp_wd);
            end else n_pass++;
            n_total++;
        end
    endtask

    task automatic test_skip_wrap();
        logic [NREQ*AW-1:0] a;
        logic [NREQ*DW-1:0] d;
        a = {5'd3, 5'd2, 5'd1, 5'd4};
        d = {32'd33, 32'd22, 32'd11, 32'd44};
        reach_run();
        step(4'b0100, a, d);          // ptr moves to 3
        step(4'b0011, a, d);
        if (obs_gnt !== 4'b0001) begin
            n_fail++; $display("FAIL wrap_gnt0: got %b expected 0001", obs_gnt);
        end else n_pass++;
        n_total++;
        step(4'b0011, a, d);
        if (obs_gnt !== 4'b0010) begin
            n_fail++; $display("FAIL wrap_gnt1: got %b expected 0010", obs_gnt);
        end else n_pass++;
        n_total++;
        step(4'b1000, a, d);
        if (obs_gnt !== 4'b1000) begin
            n_fail++; $display("FAIL only3_gnt: got %b expected 1000", obs_gnt);
        end else n_pass++;
        n_total++;
        step(4'b0110, a, d);          // ptr 0 -> requester 1 wins, ptr 2
        step('0, a, d);               // idle: ptr unchanged
        step(4'b0101, a, d);
        if (obs_gnt !== 4'b0100) begin
            n_fail++; $display("FAIL idle_keeps_ptr: got %b expected 0100", obs_gnt);
        end else n_pass++;
        n_total++;
    endtask

    task automatic test_random();
        logic [NREQ-1:0]    pend;
        logic [AW-1:0]      pa [NREQ];
        logic [DW-1:0]      pd [NREQ];
        logic [NREQ*AW-1:0] a;
        logic [NREQ*DW-1:0] d;
        pend = '0;
        for (int i = 0; i < NREQ; i++) begin pa[i] = '0; pd[i] = '0; end
        for (int c = 0; c < 250; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        pend[i] = 1'b1;
                        pa[i] = 5'($urandom_range(0, 31));
                        pd[i] = $urandom();
                    end
                end else if ($urandom_range(0, 7) == 0) begin
                    pend[i] = 1'b0;
                end
                a[i*AW +: AW] = pa[i];
                d[i*DW +: DW] = pd[i];
            end
            step(pend, a, d);
            if (obs_gnt !== exp_gnt || obs_busy !== exp_busy) begin
                n_fail++; $display("FAIL rand_gnt c=%0d: got gnt=%b busy=%b expected %b/%b", c, obs_gnt, obs_busy, exp_gnt, exp_busy);
            end else n_pass++;
            n_total++;
            if ({rf_we, rf_wa, rf_wd} !== {exp_we, exp_wa, exp_wd}) begin
                n_fail++; $display("FAIL rand_write c=%0d: got %b/%0d/%h expected %b/%0d/%h", c, rf_we, rf_wa, rf_wd, exp_we, exp_wa, exp_wd);
            end else n_pass++;
            n_total++;
            pend = pend & ~exp_gnt;
        end
        step('0, '0, '0);
        step('0, '0, '0);
        for (int i = 0; i < 32; i++) begin
            if (rf_mem[i] !== m_mem[i]) begin
                n_fail++; $display("FAIL rand_mem addr=%0d: got %h expected %h", i, rf_mem[i], m_mem[i]);
            end else n_pass++;
            n_total++;
        end
    endtask

    task automatic test_reset_mid();
        logic [NREQ*AW-1:0] a;
        logic [NREQ*DW-1:0] d;
`ifdef RF_INIT_CLEAR_EN
        do_reset();
        repeat (10) step('0, '0, '0);
        rst = 1'b1;
        #1;
        if ({rf_we, rf_wa, rf_wd} !== {1'b1 & 1'b0, 5'd0, 32'd0} || busy !== 1'b1) begin
            n_fail++; $display("FAIL mid_sweep_rst: got we=%b wa=%0d busy=%b expected 0/0/1", rf_we, rf_wa, busy);
        end else n_pass++;
        n_total++;
        do_reset();
        step('0, '0, '0);
        if ({rf_we, rf_wa, rf_wd} !== {1'b1, 5'd0, 32'd0}) begin
            n_fail++; $display("FAIL sweep_restart: got we=%b wa=%0d wd=%h expected 1/0/0", rf_we, rf_wa, rf_wd);
        end else n_pass++;
        n_total++;
`endif
        a = '0; d = '0;
        a[0 +: AW] = 5'd31;
        d[0 +: DW] = 32'd789;
        reach_run();
        step(4'b0001, a, d);
        if ({rf_we, rf_wa, rf_wd} !== {1'b1, 5'd31, 32'd789}) begin
            n_fail++; $display("FAIL mid_xfer_write: got %b/%0d/%0d expected 1/31/789", rf_we, rf_wa, rf_wd);
        end else n_pass++;
        n_total++;
        rst = 1'b1;
        #1;
        if ({rf_we, rf_wa, rf_wd} !== {1'b0, 5'd0, 32'd0}) begin
            n_fail++; $display("FAIL mid_xfer_rst: got %b/%0d/%0d expected 0/0/0", rf_we, rf_wa, rf_wd);
        end else n_pass++;
        n_total++;
        do_reset();
        if (rf_mem[31] !== m_mem[31]) begin
            n_fail++; $display("FAIL dropped_write: got rf[31]=%0d expected %0d", rf_mem[31], m_mem[31]);
        end else n_pass++;
        n_total++;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_mem[i] = 32'hDEAD_0000 | i;
        test_reset();
`ifdef RF_INIT_CLEAR_EN
        test_sweep();
        test_init_holdoff();
`endif
        test_single();
        test_round_robin();
        test_skip_wrap();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single write port (we/wa/wd) of the 32x32 register_file among NREQ requesters using round-robin arbitration with a req/gnt handshake.
- Optionally runs a power-up clear sweep that writes zero to every register before any requester is served.
- Sits between the datapath write sources (ALU writeback, load unit, debug/IO) and register_file. The register_file read ports are untouched.

Parameters:
- NREQ, 4, number of write requesters (2..8)
- AW, 5, register address width; depth = 2^AW
- DW, 32, register data width

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  NREQ  per-requester write request; held until granted
- req_addr  input  NREQ*AW  packed addresses; requester i at [i*AW +: AW]
- req_data  input  NREQ*DW  packed data; requester i at [i*DW +: DW]
- gnt  output  NREQ  one-hot grant, combinational, same cycle as req
- rf_we  output  1  registered write enable to register_file.we
- rf_wa  output  AW  registered write address to register_file.wa
- rf_wd  output  DW  registered write data to register_file.wd
- busy  output  1  high while the clear sweep runs; gnt forced 0

Behaviour:
- Reset values: rf_we=0, rf_wa=0, rf_wd=0, round-robin pointer ptr=0 (requester 0 highest priority), clear counter cnt=0.
  - State = INIT if RF_INIT_CLEAR_EN is defined, else RUN.
  - busy=1 in INIT, 0 in RUN.
- FSM:
  - INIT: gnt=0. Each edge loads rf_we=1, rf_wa=cnt, rf_wd=0, then cnt++. On the edge where cnt==2^AW-1, go to RUN.
  - RUN: arbitration, described below. There is no exit from RUN except rst.
- Arbitration in RUN: scan requesters starting at ptr, wrapping modulo NREQ. The first i with req[i]=1 gets gnt[i]=1; all other gnt bits are 0. gnt never has more than one bit set.
- Handshake: a transfer occurs on the edge where req[i]&gnt[i].
  - The requester must keep req_addr/req_data stable while req=1 and ungranted.
  - The requester may drop req or present the next write the cycle after its grant.
- Output pipeline: on a transfer edge, rf_we<=1, rf_wa<=addr_i, rf_wd<=data_i, and ptr<=(i+1) mod NREQ.
  - On a RUN edge with no req, rf_we<=0, and rf_wa/rf_wd hold their previous values.
- Latency: grant in cycle N; register_file write on edge N+2; data visible on rd0/rd1 from cycle N+2.
- Throughput: one write per cycle. With all requesters asserting continuously, each is granted once every NREQ cycles.
- Address 0 is not special-cased: writes to 0 are forwarded unchanged.
- Boundaries:
  - A req arriving during INIT is held off (gnt=0) until the first RUN cycle.
  - The last clear write (wa=2^AW-1) appears on the rf_* outputs in the first RUN cycle. A grant in that cycle is legal and its write follows on the next cycle, so there is no port conflict.
  - A requester that deasserts req without being granted is simply skipped; ptr does not change.
  - rst asserted mid-sweep or mid-transfer: all state returns immediately to the reset values. INIT restarts from cnt=0, and any pending registered write is dropped (rf_we=0).

Optional Feature:
- RF_INIT_CLEAR_EN
  - Defined: reset enters INIT, and the 2^AW-cycle zero sweep runs as above. busy=1 throughout.
  - Undefined: the INIT state and cnt are not built. Reset enters RUN directly, busy is tied 0, and the register_file contents after reset are whatever the file holds.

Test Plan:
- Clear sweep (macro on): release rst with req=0. rf_we=1 with rf_wa=0..31 on 32 consecutive cycles, rf_wd=0, busy=1 for exactly 32 cycles. Afterwards register_file rd0 reads 0 for ra0=0..31.
- Single requester: req=4'b0100, addr=20, data=378 in the first RUN cycle. gnt=4'b0100 the same cycle, rf_we=1/wa=20/wd=378 the next cycle, rd1 with ra1=20 returns 378 one cycle later.
- Round-robin fairness: req=4'b1111 held with distinct addr/data for 8 cycles. Grant sequence is 0,1,2,3,0,1,2,3 and writes land in that order.
- Skip and wrap: ptr=3, req=4'b0011 → gnt=4'b0001, then gnt=4'b0010. With req=4'b1000 only → gnt=4'b1000 immediately.
- Held off during INIT: req[1]=1 from the first cycle after rst. gnt=0 while busy=1, gnt[1]=1 in the first cycle busy=0.
- Reset mid-operation: assert rst at sweep cnt=10, or the cycle after a grant of (31, 789). Outputs drop to 0 immediately, no write to 31 occurs, and the sweep restarts at wa=0.
